motor_drive_monitor: RTL and testbench



---
 rtl/motor_drive_monitor_pkg.sv | 32 +++
 rtl/motor_drive_monitor_if.sv | 33 +++
 rtl/motor_drive_monitor_pwm_channel_meter.sv | 121 ++++++++++++
 rtl/motor_drive_monitor.sv | 60 ++++++
 tb/tb_motor_drive_monitor.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/motor_drive_monitor_pkg.sv
// Shared definitions for the motor drive monitor: direction codes, the
// per-motor FSM states and the bit positions of IN1..IN4 on the motor bus.
package motor_drive_monitor_pkg;

  typedef enum logic [1:0] {
    DIR_STOP  = 2'b00,
    DIR_FWD   = 2'b01,
    DIR_REV   = 2'b10,
    DIR_FAULT = 2'b11
  } dir_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEAS = 1'b1
  } state_e;

  // motor = {IN4,IN3,IN2,IN1}
  localparam int IN1 = 0;
  localparam int IN2 = 1;
  localparam int IN3 = 2;
  localparam int IN4 = 3;

  function automatic dir_e dir_enc(input logic fwd, input logic rev);
    case ({rev, fwd})
      2'b01:   return DIR_FWD;
      2'b10:   return DIR_REV;
      2'b11:   return DIR_FAULT;
      default: return DIR_STOP;
    endcase
  endfunction

endpackage

// File: rtl/motor_drive_monitor_if.sv
// Bus between the H-bridge drive side and the monitor.
//   motor            : observed {IN4,IN3,IN2,IN1}
//   valid_a/valid_b  : one-cycle measurement strobes
//   period_*/high_*  : measured PWM period / high time in clk cycles
//   dir_*            : 00 STOP, 01 FWD, 10 REV, 11 FAULT
//   fault            : sticky shoot-through flags {B,A}
// master = drive side (owns motor), slave = monitor (owns results).
interface motor_drive_monitor_if #(
  parameter int CNT_W = 16
) ();
  logic [3:0]       motor;
  logic             valid_a;
  logic             valid_b;
  logic [CNT_W-1:0] period_a;
  logic [CNT_W-1:0] period_b;
  logic [CNT_W-1:0] high_a;
  logic [CNT_W-1:0] high_b;
  logic [1:0]       dir_a;
  logic [1:0]       dir_b;
  logic [1:0]       fault;

  modport master (
    output motor,
    input  valid_a, valid_b, period_a, period_b, high_a, high_b,
           dir_a, dir_b, fault
  );

  modport slave (
    input  motor,
    output valid_a, valid_b, period_a, period_b, high_a, high_b,
           dir_a, dir_b, fault
  );
endinterface

// File: rtl/motor_drive_monitor_pwm_channel_meter.sv
// One-motor PWM meter: period/high-time counters, IDLE/MEAS FSM,
// direction decode, sticky shoot-through flag and report registers.
//   clk, rst      : clock, async active-high reset
//   fwd_s, rev_s  : synchronized forward/reverse pins
//   fwd_p, rev_p  : same pins one cycle earlier (edge detection)
//   valid         : one-cycle report strobe
//   period, high  : reported period / high time
//   dir           : reported direction, forced to FAULT once fault is set
//   fault         : sticky shoot-through flag
module pwm_channel_meter
  import motor_drive_monitor_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_s,
  input  logic             rev_s,
  input  logic             fwd_p,
  input  logic             rev_p,
  output logic             valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high,
  output logic [1:0]       dir,
  output logic             fault
);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  // Registered view of the pins: one stage so a pin rise sampled at edge k
  // is acted on at edge k+3.
  logic fwd_r, rev_r, rise_r, act_r;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fwd_r  <= 1'b0;
      rev_r  <= 1'b0;
      rise_r <= 1'b0;
    end else begin
      fwd_r  <= fwd_s;
      rev_r  <= rev_s;
      rise_r <= (fwd_s | rev_s) & ~(fwd_p | rev_p);
    end
  assign act_r = fwd_r | rev_r;

  state_e           state, state_nxt;
  logic [CNT_W-1:0] period_cnt, high_cnt;
  logic             fwd_seen, rev_seen;
  logic             restart, report, tmo_hit;

  assign tmo_hit = (period_cnt == TMO);

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;

  // Rise beats timeout in MEAS, so PWM period == TIMEOUT stays in MEAS.
  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    report    = 1'b0;
    case (state)
      ST_IDLE:
        if (rise_r) begin
          restart   = 1'b1;
          state_nxt = ST_MEAS;
        end else if (tmo_hit) begin
          restart = 1'b1;
          report  = 1'b1;
        end
      ST_MEAS:
        if (rise_r || tmo_hit) begin
          restart = 1'b1;
          report  = 1'b1;
          if (!rise_r) state_nxt = ST_IDLE;
        end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Counters hold the totals for the cycles before the current one; a
  // restart loads the current cycle as the first of the new window.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      period_cnt <= '0;
      high_cnt   <= '0;
      fwd_seen   <= 1'b0;
      rev_seen   <= 1'b0;
    end else if (restart) begin
      period_cnt <= CNT_W'(1);
      high_cnt   <= CNT_W'(act_r);
      fwd_seen   <= fwd_r;
      rev_seen   <= rev_r;
    end else begin
      period_cnt <= period_cnt + CNT_W'(1);
      high_cnt   <= high_cnt + CNT_W'(act_r);
      fwd_seen   <= fwd_seen | fwd_r;
      rev_seen   <= rev_seen | rev_r;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid  <= 1'b0;
      period <= '0;
      high   <= '0;
      dir    <= DIR_STOP;
      fault  <= 1'b0;
    end else begin
      valid <= report;
      if (report) begin
        period <= period_cnt;
        // A static window only reports high time if act never dropped.
        high   <= (state == ST_MEAS || high_cnt == TMO) ? high_cnt : '0;
        dir    <= fault ? DIR_FAULT : dir_enc(fwd_seen, rev_seen);
      end
      if (fwd_r && rev_r) begin
        fault <= 1'b1;
        dir   <= DIR_FAULT;
      end
    end

endmodule

// File: rtl/motor_drive_monitor.sv
// Passive monitor on the H-bridge bus {IN4,IN3,IN2,IN1}. Synchronizes the
// bus and feeds one PWM meter per motor (A = {IN2,IN1}, B = {IN4,IN3}).
//   clk, rst : clock, async active-high reset
//   bus      : slave side of motor_drive_monitor_if (motor in, results out)
module motor_drive_monitor
  import motor_drive_monitor_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  motor_drive_monitor_if.slave bus
);
  logic [3:0] sync1, sync2, sync_prev;
  logic       fault_a, fault_b;

  // 2-flop synchronizer plus a history register for edge detection.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
    end else begin
      sync1     <= bus.motor;
      sync2     <= sync1;
      sync_prev <= sync2;
    end

  pwm_channel_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_meter_a (
    .clk    (clk),
    .rst    (rst),
    .fwd_s  (sync2[IN1]),
    .rev_s  (sync2[IN2]),
    .fwd_p  (sync_prev[IN1]),
    .rev_p  (sync_prev[IN2]),
    .valid  (bus.valid_a),
    .period (bus.period_a),
    .high   (bus.high_a),
    .dir    (bus.dir_a),
    .fault  (fault_a)
  );

  pwm_channel_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_meter_b (
    .clk    (clk),
    .rst    (rst),
    .fwd_s  (sync2[IN4]),
    .rev_s  (sync2[IN3]),
    .fwd_p  (sync_prev[IN4]),
    .rev_p  (sync_prev[IN3]),
    .valid  (bus.valid_b),
    .period (bus.period_b),
    .high   (bus.high_b),
    .dir    (bus.dir_b),
    .fault  (fault_b)
  );

  assign bus.fault = {fault_b, fault_a};

endmodule

// File: tb/tb_motor_drive_monitor.sv
// Directed bench for motor_drive_monitor with TIMEOUT = 1000.
module tb_motor_drive_monitor;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  motor_drive_monitor_if #(.CNT_W(CNT_W)) bus ();

  motor_drive_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // PWM / static-level driver; restarts phase 0 whenever pwm_gen changes.
  logic       pwm_on     = 1'b0;
  logic [3:0] pwm_mask   = 4'b0;
  logic [3:0] static_val = 4'b0;
  int         pwm_per    = 100;
  int         pwm_hi     = 30;
  int         pwm_gen    = 0;

  initial begin
    int ph;
    int last_gen;
    ph       = 0;
    last_gen = 0;
    bus.motor = 4'b0;
    forever begin
      @(posedge clk);
      #2;
      if (pwm_on) begin
        if (pwm_gen != last_gen) begin
          last_gen = pwm_gen;
          ph       = 0;
        end
        bus.motor = (ph < pwm_hi) ? pwm_mask : 4'b0;
        ph        = (ph + 1 == pwm_per) ? 0 : ph + 1;
      end else begin
        bus.motor = static_val;
      end
    end
  end

  // Background observers: valid_b activity and back-to-back valid pulses.
  int   vb_cnt = 0;
  int   dbl_a  = 0;
  int   dbl_b  = 0;
  logic pva    = 1'b0;
  logic pvb    = 1'b0;
  always @(negedge clk) begin
    if (bus.valid_b) vb_cnt <= vb_cnt + 1;
    if (bus.valid_a && pva) dbl_a <= dbl_a + 1;
    if (bus.valid_b && pvb) dbl_b <= dbl_b + 1;
    pva <= bus.valid_a;
    pvb <= bus.valid_b;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Counts negedges until valid_a is seen; n = 0 if the bound expires.
  task automatic wait_va(input int bound, output int n);
    logic found;
    found = 1'b0;
    n     = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (bus.valid_a) begin
        n     = i;
        found = 1'b1;
        break;
      end
    end
    chk("wait_valid_a", 32'(found), 32'd1);
  endtask

  task automatic start_pwm(input logic [3:0] m, input int p, input int h);
    @(posedge clk);
    #1;
    pwm_mask = m;
    pwm_per  = p;
    pwm_hi   = h;
    pwm_gen++;
    pwm_on   = 1'b1;
  endtask

  task automatic set_static(input logic [3:0] v);
    @(posedge clk);
    #1;
    pwm_on     = 1'b0;
    static_val = v;
  endtask

  initial begin
    int n;
    int vb0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_a",  32'(bus.valid_a),  0);
    chk("rst_valid_b",  32'(bus.valid_b),  0);
    chk("rst_period_a", 32'(bus.period_a), 0);
    chk("rst_high_a",   32'(bus.high_a),   0);
    chk("rst_dir_a",    32'(bus.dir_a),    0);
    chk("rst_fault",    32'(bus.fault),    0);
    @(negedge clk) rst = 1'b0;

    // Forward PWM 100/30 on IN1: first report after the second rise,
    // rise sampled at edge P0+1 -> valid after edge P0+104 -> 105th negedge.
    start_pwm(4'b0001, 100, 30);
    wait_va(300, n);
    chk("fwd_first_lat", n, 105);
    chk("fwd_period_a", 32'(bus.period_a), 100);
    chk("fwd_high_a",   32'(bus.high_a),   30);
    chk("fwd_dir_a",    32'(bus.dir_a),    1);
    wait_va(300, n);
    chk("fwd_interval", n, 100);

    // Asynchronous reset mid-period clears outputs immediately
    repeat (50) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid_a",  32'(bus.valid_a),  0);
    chk("arst_period_a", 32'(bus.period_a), 0);
    chk("arst_high_a",   32'(bus.high_a),   0);
    chk("arst_dir_a",    32'(bus.dir_a),    0);
    pwm_on     = 1'b0;
    static_val = 4'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    vb0 = vb_cnt;
    repeat (5) @(negedge clk);

    // After release the first report again needs two rises
    start_pwm(4'b0001, 100, 30);
    wait_va(300, n);
    chk("rst_relaunch_lat", n, 105);
    chk("rst_period_a", 32'(bus.period_a), 100);
    wait_va(300, n);
    chk("fwd2_interval", n, 100);
    chk("fwd2_period_a", 32'(bus.period_a), 100);
    chk("fwd2_high_a",   32'(bus.high_a),   30);
    chk("fwd2_dir_a",    32'(bus.dir_a),    1);
    chk("fwd_b_silent",  vb_cnt - vb0,      0);

    // Both motors forward on a shared 200/150 PWM (IN4 and IN1)
    start_pwm(4'b1001, 200, 150);
    wait_va(500, n);
    wait_va(500, n);
    chk("both_interval", n, 200);
    chk("both_valid_b",  32'(bus.valid_b),  1);
    chk("both_period_a", 32'(bus.period_a), 200);
    chk("both_high_a",   32'(bus.high_a),   150);
    chk("both_dir_a",    32'(bus.dir_a),    1);
    chk("both_period_b", 32'(bus.period_b), 200);
    chk("both_high_b",   32'(bus.high_b),   150);
    chk("both_dir_b",    32'(bus.dir_b),    1);

    // Static 0: timeout out of MEAS, then an IDLE report every TIMEOUT
    set_static(4'b0000);
    wait_va(1500, n);
    wait_va(1500, n);
    chk("idle0_interval", n, 1000);
    chk("idle0_period_a", 32'(bus.period_a), 1000);
    chk("idle0_high_a",   32'(bus.high_a),   0);
    chk("idle0_dir_a",    32'(bus.dir_a),    0);

    // Static IN1 = 1: MEAS timeout then IDLE reports, high = TIMEOUT
    set_static(4'b0001);
    wait_va(1500, n);
    chk("hi1_period_a", 32'(bus.period_a), 1000);
    chk("hi1_high_a",   32'(bus.high_a),   1000);
    chk("hi1_dir_a",    32'(bus.dir_a),    1);
    wait_va(1500, n);
    chk("hi1_interval", n, 1000);
    chk("hi1_idle_high_a", 32'(bus.high_a), 1000);
    chk("hi1_idle_dir_a",  32'(bus.dir_a),  1);

    // Reverse PWM on IN2
    start_pwm(4'b0010, 100, 30);
    wait_va(400, n);
    chk("rev_period_a", 32'(bus.period_a), 100);
    chk("rev_high_a",   32'(bus.high_a),   30);
    chk("rev_dir_a",    32'(bus.dir_a),    2);

    // One-cycle IN1&IN2 overlap, first sampled at edge k = P1
    @(posedge clk);
    #1;
    pwm_on     = 1'b0;
    static_val = 4'b0011;
    @(posedge clk);
    #1;
    static_val = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("fault_early", 32'(bus.fault), 0);
    @(posedge clk);
    #1;
    chk("fault_set", 32'(bus.fault), 1);
    @(posedge clk);
    #1;
    chk("fault_dir_a", 32'(bus.dir_a), 3);
    wait_va(2500, n);
    chk("fault_sticky",     32'(bus.fault), 1);
    chk("fault_dir_sticky", 32'(bus.dir_a), 3);

    // Only reset clears the fault
    @(negedge clk) rst = 1'b1;
    #1;
    chk("fault_rst_clear", 32'(bus.fault), 0);
    chk("fault_rst_dir_a", 32'(bus.dir_a), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // PWM period equal to TIMEOUT: rise wins, no IDLE gap between reports
    start_pwm(4'b0001, 1000, 400);
    wait_va(2200, n);
    chk("tmo_first_lat", n, 1005);
    chk("tmo_period_a",  32'(bus.period_a), 1000);
    chk("tmo_high_a",    32'(bus.high_a),   400);
    chk("tmo_dir_a",     32'(bus.dir_a),    1);
    wait_va(1500, n);
    chk("tmo_interval",  n, 1000);
    chk("tmo_period2_a", 32'(bus.period_a), 1000);

    @(negedge clk);
    chk("valid_a_single", dbl_a, 0);
    chk("valid_b_single", dbl_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
